// File: rtl/xmas_led_pkg.sv
// Shared definitions for the LED chaser: mode encodings, FSM states and helpers.
package xmas_led_pkg;

    localparam logic [1:0] MODE_CHASE  = 2'd0;
    localparam logic [1:0] MODE_BOUNCE = 2'd1;
    localparam logic [1:0] MODE_FLASH  = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHASE,
        ST_BOUNCE,
        ST_FLASH,
        ST_HOLD
    } state_t;

    // Patterns narrower than 32 bits are zero-extended by the caller.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/xmas_led_pwm.sv
// Brightness gate: free-running counter compared against duty, with the
// all-ones and zero duty values forcing fully on / fully off.
module xmas_led_pwm #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                on
);

    localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    logic [PWM_BITS-1:0] pwm_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_ONE;
        end
    end

    always_comb begin
        on = 1'b0;
        if (duty == '1) begin
            on = 1'b1;
        end else if (duty != '0) begin
            on = (pwm_cnt_reg < duty);
        end
    end

endmodule

// File: rtl/xmas_led_chaser.sv
// Multi-LED pattern engine stepped by each level change of the blinker output,
// with a PWM brightness gate on the registered LED bank.
module xmas_led_chaser
    import xmas_led_pkg::*;
#(
    parameter int N_LEDS   = 8,
    parameter int PWM_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_in,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_LEDS-1:0]   leds,
    output logic [CNT_BITS-1:0] step_count
);

    localparam logic [N_LEDS-1:0]   PAT_FIRST = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ONE   = {{(CNT_BITS-1){1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic                step_d_reg;
    logic                step;
    logic [N_LEDS-1:0]   pattern_reg, pattern_next;
    logic                dir_reg, dir_next;
    logic                bounce_dir;
    logic                onehot;
    logic [N_LEDS-1:0]   leds_reg, leds_next;
    logic [CNT_BITS-1:0] count_reg;
    logic                on;

    assign step   = step_in ^ step_d_reg;
    assign onehot = is_onehot(32'(pattern_reg));

    xmas_led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty),
        .on   (on)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            step_d_reg  <= 1'b0;
            pattern_reg <= '0;
            dir_reg     <= 1'b1;
            count_reg   <= '0;
            leds_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            step_d_reg  <= step_in;
            pattern_reg <= pattern_next;
            dir_reg     <= dir_next;
            leds_reg    <= leds_next;
            if (step) begin
                count_reg <= count_reg + CNT_ONE;
            end
        end
    end

    // HOLD selected from IDLE keeps the block idle with a dark pattern.
    always_comb begin
        state_next = state_reg;
        if (step) begin
            case (mode)
                MODE_CHASE:  state_next = ST_CHASE;
                MODE_BOUNCE: state_next = ST_BOUNCE;
                MODE_FLASH:  state_next = ST_FLASH;
                default:     state_next = (state_reg == ST_IDLE) ? ST_IDLE : ST_HOLD;
            endcase
        end
    end

    always_comb begin
        pattern_next = pattern_reg;
        dir_next     = dir_reg;
        // Leaving CHASE restarts upward; endpoints always force the legal direction.
        bounce_dir   = (state_reg == ST_CHASE) ? 1'b1 : dir_reg;
        if (pattern_reg[N_LEDS-1]) begin
            bounce_dir = 1'b0;
        end else if (pattern_reg[0]) begin
            bounce_dir = 1'b1;
        end
        if (step) begin
            case (mode)
                MODE_CHASE: begin
                    if (!onehot) begin
                        pattern_next = PAT_FIRST;
                        dir_next     = 1'b1;
                    end else begin
                        pattern_next = {pattern_reg[N_LEDS-2:0], pattern_reg[N_LEDS-1]};
                    end
                end
                MODE_BOUNCE: begin
                    if (!onehot) begin
                        pattern_next = PAT_FIRST;
                        dir_next     = 1'b1;
                    end else if (bounce_dir) begin
                        pattern_next = pattern_reg << 1;
                        dir_next     = ~pattern_reg[N_LEDS-2];
                    end else begin
                        pattern_next = pattern_reg >> 1;
                        dir_next     = pattern_reg[1];
                    end
                end
                MODE_FLASH: begin
                    if ((pattern_reg == '0) || (pattern_reg == '1)) begin
                        pattern_next = ~pattern_reg;
                    end else begin
                        pattern_next = '1;
                    end
                end
                default: begin
                    pattern_next = pattern_reg;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_gate
        assign leds_next[gi] = pattern_reg[gi] & on;
    end

    assign leds       = leds_reg;
    assign step_count = count_reg;

endmodule

// File: tb/tb_xmas_led_chaser.sv
// Directed bench for xmas_led_chaser: expected LED/count values are queued when
// a step is driven and compared once the DUT has had time to show them.
module tb_xmas_led_chaser;
    import xmas_led_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_in = 1'b0;
    logic [1:0]  mode = MODE_CHASE;
    logic [3:0]  duty = 4'hF;
    logic [7:0]  leds;
    logic [15:0] step_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  leds;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];

    xmas_led_chaser #(
        .N_LEDS   (8),
        .PWM_BITS (4),
        .CNT_BITS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_in    (step_in),
        .mode       (mode),
        .duty       (duty),
        .leds       (leds),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        step_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One step: toggle before edge t, glitch mode after it, compare after edge t+1.
    task automatic do_step(input logic [1:0] m, input logic [7:0] el,
                           input logic [15:0] ec, input string tag, input int gap);
        exp_t e;
        @(negedge clk);
        mode    = m;
        step_in = ~step_in;
        e.leds  = el;
        e.cnt   = ec;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clk);
        mode = ~m;
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, "_leds"}, 16'(leds), 16'(e.leds));
        check({e.tag, "_cnt"}, step_count, e.cnt);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] bounce_tab [16];
        logic [7:0] flash_tab [4];
        logic [3:0] duty_tab [3];
        int         hi_tab [3];
        int         hi;
        logic       lvl;

        bounce_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                       8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        flash_tab  = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        duty_tab   = '{4'd4, 4'd0, 4'd15};
        hi_tab     = '{4, 0, 16};

        // Reset state and spaced chase steps
        do_reset();
        @(negedge clk);
        check("reset_leds", 16'(leds), 16'h0000);
        check("reset_cnt", step_count, 16'h0000);
        do_step(MODE_CHASE, 8'h01, 16'd1, "chase0", 1);
        do_step(MODE_CHASE, 8'h02, 16'd2, "chase1", 1);
        do_step(MODE_CHASE, 8'h04, 16'd3, "chase2", 1);

        // Bounce full sweep, back-to-back cadence
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_step(MODE_BOUNCE, bounce_tab[i], 16'(i + 1), $sformatf("bounce%0d", i), 0);
        end

        // Flash from idle, then into chase
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_step(MODE_FLASH, flash_tab[i], 16'(i + 1), $sformatf("flash%0d", i), 0);
        end
        do_step(MODE_CHASE, 8'h01, 16'd5, "flash_to_chase", 0);

        // Chase to top bit, then switch to bounce
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_step(MODE_CHASE, 8'(1 << i), 16'(i + 1), $sformatf("chase_up%0d", i), 0);
        end
        do_step(MODE_BOUNCE, 8'h40, 16'd9, "chase_to_bounce", 0);
        do_step(MODE_BOUNCE, 8'h20, 16'd10, "bounce_dir_down", 0);

        // PWM duty gating on a single lit LED
        do_reset();
        do_step(MODE_CHASE, 8'h01, 16'd1, "pwm_setup", 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            duty = duty_tab[k];
            @(negedge clk);
            hi = 0;
            for (int c = 0; c < 16; c++) begin
                hi += int'(leds[0]);
                @(negedge clk);
            end
            check($sformatf("pwm_duty%0d", duty_tab[k]), 16'(hi), 16'(hi_tab[k]));
        end
        duty = 4'hF;

        // Step counter wrap while holding in idle
        do_reset();
        mode = MODE_HOLD;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            step_in = ~step_in;
        end
        @(negedge clk);
        @(negedge clk);
        check("near_wrap_cnt", step_count, 16'hFFFF);
        check("hold_idle_leds", 16'(leds), 16'h0000);
        do_step(MODE_HOLD, 8'h00, 16'h0000, "wrap", 0);
        do_step(MODE_CHASE, 8'h01, 16'd1, "after_wrap", 0);
        do_step(MODE_CHASE, 8'h02, 16'd2, "pre_rst", 0);

        // Reset coincident with a step: absorbed, then relative to 0
        @(negedge clk);
        mode    = MODE_CHASE;
        step_in = ~step_in;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lvl = step_in;
        check("rst_step_leds", 16'(leds), 16'h0000);
        check("rst_step_cnt", step_count, 16'h0000);
        @(negedge clk);
        check("post_rst_cnt", step_count, lvl ? 16'd1 : 16'd0);
        @(negedge clk);
        check("post_rst_leds", 16'(leds), lvl ? 16'h0001 : 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xmas_led_chaser.md
# xmas_led_chaser

Downstream consumer of the single-LED blinker's `led` output. Every level change of that output is one step. On each step the block advances a multi-LED pattern: chase, bounce, flash, or hold. The result is gated by a brightness PWM and drives the board's LED bank.

## Interface
Parameters:
- `N_LEDS`, 8: number of LED outputs; legal range 2..32.
- `PWM_BITS`, 4: width of the PWM counter and of `duty`.
- `CNT_BITS`, 16: width of `step_count`.

Ports:
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `step_in`: input, 1 bit. Blinker `led` level. Synchronous to `clk`. Each transition, either direction, is one step.
- `mode`: input, 2 bits. 0 = CHASE, 1 = BOUNCE, 2 = FLASH, 3 = HOLD. Sampled only on a step.
- `duty`: input, `PWM_BITS` bits. Brightness. Sampled every cycle.
- `leds`: output, `N_LEDS` bits. Registered, PWM-gated pattern.
- `step_count`: output, `CNT_BITS` bits. Registered count of steps; wraps.

## Operation
- Edge detect: `step_d` is the registered copy of `step_in`. `step = step_in ^ step_d`.
- Internal registers: `pattern[N_LEDS-1:0]`, direction bit `dir` (1 = up), and `state`.
- State machine states: IDLE, CHASE, BOUNCE, FLASH, HOLD. State changes only on a cycle with `step`. The target state is the one selected by `mode`.
- IDLE (after reset), on a step:
  - mode CHASE or BOUNCE: `pattern` = 1 (bit 0 set), `dir` = 1.
  - mode FLASH: `pattern` = all ones.
  - mode HOLD: remain in IDLE with `pattern` = 0.
- CHASE on a step: rotate left; bit `N_LEDS-1` wraps to bit 0.
- BOUNCE on a step:
  - `dir` = 1: shift left; on reaching bit `N_LEDS-1`, set `dir` = 0.
  - `dir` = 0: shift right; on reaching bit 0, set `dir` = 1.
  - Result: the endpoints are each lit for one step only.
- FLASH on a step: `pattern` = ~`pattern` if it is all ones or all zeros; otherwise `pattern` = all ones.
- HOLD on a step: `pattern` unchanged. `step_count` still increments.
- Mode switch on a step:
  - Into CHASE or BOUNCE: if `pattern` is not one-hot, load bit 0 with `dir` = 1, then apply no further move that step. If one-hot, keep the position and apply one move of the new mode.
  - Into BOUNCE from CHASE: `dir` = 1, except at bit `N_LEDS-1` where `dir` = 0 and the bit moves to `N_LEDS-2`.
- `step_count` increments on every step and wraps from all ones to 0.
- PWM: `pwm_cnt` is a free-running `PWM_BITS` counter, wrapping every 2^PWM_BITS cycles. Gate `on` is:
  - 1 when `duty` is all ones;
  - 0 when `duty` = 0;
  - otherwise `pwm_cnt < duty`.
- `leds <= pattern & {N_LEDS{on}}`.
- Reset values: `leds` = 0, `step_count` = 0, `pattern` = 0, `dir` = 1, `step_d` = 0, `pwm_cnt` = 0, state = IDLE.

## Timing
- Latency: `step_in` toggles before edge t. `pattern` and `step_count` update at edge t. `leds` reflects the new pattern at edge t+1, when `on` = 1.
- Back-to-back steps are legal: toggling on consecutive cycles produces one move per cycle, with no loss.
- `mode` is sampled only in the step cycle. A mode glitch between steps has no effect.
- `duty` change: takes effect on `leds` one cycle later. No wait for a PWM period boundary.
- `rst` mid-run: all registers return to reset values at that edge. A `step_in` transition in the reset cycle is absorbed: `step_d` is loaded, but `step_d` reset to 0 has priority. The first step after reset is then the next level change relative to 0.
- `step_in` = 1 at reset release produces one step on the first cycle after release. This is intended and matches the blinker driving `led` = 1 first.

## Structure
- Shared package `xmas_led_pkg`:
  - mode encoding constants (CHASE, BOUNCE, FLASH, HOLD);
  - state enum;
  - `is_onehot` function.
- One sub-module, `xmas_led_pwm`: `pwm_cnt` plus the `duty` compare. Output `on`.
- Remainder is one module: edge detect, FSM, pattern registers, output register.

## Test plan
- Reset with `mode` = 0 and `duty` = 15, then toggle `step_in` 3 times, spaced 4 cycles apart. Required, at step edge +1: `leds` = 0x01, 0x02, 0x04; `step_count` = 3.
- BOUNCE, `N_LEDS` = 8, 16 steps. Required sequence: 01, 02, 04, 08, 10, 20, 40, 80, 40, 20, 10, 08, 04, 02, 01, 02.
- FLASH from IDLE, 4 steps: `leds` = FF, 00, FF, 00. Then switch to CHASE at the next step: `leds` = 01.
- CHASE at `pattern` = 0x80, next step with `mode` = 1: `leds` = 0x40 and `dir` = 0.
- `duty` = 4, CHASE pattern 0x01: over 16 cycles `leds`[0] is high for exactly 4 cycles. `duty` = 0: always 0. `duty` = 15: always 1.
- `step_count` preset near wrap via 65536 steps: wraps to 0. Assert `rst` in the same cycle as a step: `leds` = 0 next cycle, state = IDLE, no count.
